vga_term_ctrl: RTL and testbench

//  Terminal controller in front of the VGA text path: accepts Apple-1 display bytes over a

---
 rtl/vga_term_ctrl.sv | 136 +++++++++++++
 tb/tb_vga_term_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_term_ctrl.sv
// Terminal controller: turns Apple-1 display bytes into glyph writes in video RAM.
// Tracks the cursor and handles wrap and CR. Scrolling rotates row_offset and blanks the recycled row.
module vga_term_ctrl #(
  parameter int COLS   = 40,
  parameter int ROWS   = 24,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_char,
  output logic              in_ready,
  input  logic              clr,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [5:0]        vram_wdata,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic [4:0]        row_offset,
  output logic              busy
);

  localparam int CELLS = ROWS * COLS;

  typedef enum logic [2:0] {IDLE, WRITE, NEWLINE, CLEAR_LINE, CLEAR_ALL} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] line_base;
  logic              clr_pend;

  logic              clr_req;
  logic              accept;
  logic [6:0]        c;
  logic [5:0]        glyph;
  logic              printable;
  logic [5:0]        row_sum;
  logic [4:0]        phys_row;
  logic [ADDR_W-1:0] cell_addr;
  logic              unused_bit7;

  assign unused_bit7 = in_char[7];
  assign c           = in_char[6:0];
  assign glyph       = {c[6] ? 1'b0 : c[5], c[4:0]};
  assign printable   = (c >= 7'h20) && (c <= 7'h7E);

  // A clr arriving this cycle already blocks the byte, so clr always wins over in_valid.
  assign clr_req  = clr_pend | clr;
  assign in_ready = (state == IDLE) && !clr_req;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  assign row_sum   = {1'b0, cursor_row} + {1'b0, row_offset};
  assign phys_row  = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
  assign cell_addr = ADDR_W'(phys_row) * ADDR_W'(COLS) + ADDR_W'(cursor_col);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CLEAR_ALL;
      cnt        <= '0;
      line_base  <= '0;
      clr_pend   <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 6'h20;
      cursor_col <= '0;
      cursor_row <= '0;
      row_offset <= '0;
    end else begin
      vram_we <= 1'b0;
      if (clr) clr_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_req) begin
            clr_pend <= 1'b0;
            cnt      <= '0;
            state    <= CLEAR_ALL;
          end else if (accept) begin
            if (c == 7'h0D) begin
              state <= NEWLINE;
            end else if (printable) begin
              // Write is issued here so it lands in the WRITE cycle.
              vram_we    <= 1'b1;
              vram_addr  <= cell_addr;
              vram_wdata <= glyph;
              state      <= WRITE;
            end
          end
        end
        WRITE: begin
          if (cursor_col == 6'(COLS - 1)) begin
            state <= NEWLINE;
          end else begin
            cursor_col <= cursor_col + 6'd1;
            state      <= IDLE;
          end
        end
        NEWLINE: begin
          cursor_col <= '0;
          if (cursor_row < 5'(ROWS - 1)) begin
            cursor_row <= cursor_row + 5'd1;
            state      <= IDLE;
          end else begin
            // The old top row becomes the new bottom row and must be blanked.
            line_base  <= ADDR_W'(row_offset) * ADDR_W'(COLS);
            row_offset <= (row_offset == 5'(ROWS - 1)) ? 5'd0 : row_offset + 5'd1;
            cnt        <= '0;
            state      <= CLEAR_LINE;
          end
        end
        CLEAR_LINE: begin
          vram_we    <= 1'b1;
          vram_addr  <= line_base + cnt;
          vram_wdata <= 6'h20;
          if (cnt == ADDR_W'(COLS - 1)) state <= IDLE;
          else                          cnt   <= cnt + 1'b1;
        end
        CLEAR_ALL: begin
          vram_we    <= 1'b1;
          vram_addr  <= cnt;
          vram_wdata <= 6'h20;
          if (cnt == ADDR_W'(CELLS - 1)) begin
            cursor_col <= '0;
            cursor_row <= '0;
            row_offset <= '0;
            state      <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_term_ctrl.sv
// Directed bench for vga_term_ctrl: reset clear, glyph mapping, wrap, scroll, clear and reset abort.
module tb_vga_term_ctrl;

  logic       clk = 1'b0;
  logic       rst, in_valid, clr;
  logic [7:0] in_char;
  logic       in_ready, vram_we, busy;
  logic [9:0] vram_addr;
  logic [5:0] vram_wdata, cursor_col;
  logic [4:0] cursor_row, row_offset;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] wq_addr[$];
  logic [5:0] wq_data[$];

  vga_term_ctrl #(.COLS(40), .ROWS(24), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
    .clr(clr), .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
    .cursor_col(cursor_col), .cursor_row(cursor_row), .row_offset(row_offset), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (vram_we === 1'b1) begin
      wq_addr.push_back(vram_addr);
      wq_data.push_back(vram_wdata);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_seg(input string tag, input int qoff, input int base, input int n, input int data);
    int errs = 0;
    for (int i = 0; i < n; i++) begin
      if (qoff + i >= wq_addr.size()) errs++;
      else if (int'(wq_addr[qoff+i]) != base + i || int'(wq_data[qoff+i]) != data) errs++;
    end
    chk(tag, errs, 0);
  endtask

  task automatic qclear();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic wait_ready(input string tag, input int lim);
    int n = 0;
    while (in_ready !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, int'(in_ready), 1);
  endtask

  // Returns the vram_we level seen one cycle after the byte is accepted.
  task automatic send(input logic [7:0] b, output int we_next);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_char  = b;
    while (in_ready !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) chk("send_timeout", 0, 1);
    @(negedge clk);
    we_next  = int'(vram_we);
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_ready("clear", 3000);
    qclear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int we;
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0; in_char = 8'h00;

    // T1: reset values, then a full 960-cell clear
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_we", int'(vram_we), 0);
    chk("rst_addr", int'(vram_addr), 0);
    chk("rst_wdata", int'(vram_wdata), 32);
    chk("rst_busy", int'(busy), 1);
    rst = 1'b0;
    qclear();
    wait_ready("t1", 2000);
    chk("t1_nwrites", wq_addr.size(), 960);
    chk_seg("t1_seq", 0, 0, 960, 32);
    chk("t1_busy", int'(busy), 0);
    chk("t1_col", int'(cursor_col), 0);
    chk("t1_row", int'(cursor_row), 0);

    // T2: upper and lower case 'A' both map to glyph 1
    qclear();
    send(8'hC1, we);
    chk("t2_latency", we, 1);
    send(8'h61, we);
    wait_ready("t2", 20);
    chk("t2_nwrites", wq_addr.size(), 2);
    chk_seg("t2_w0", 0, 0, 1, 1);
    chk_seg("t2_w1", 1, 1, 1, 1);
    chk("t2_col", int'(cursor_col), 2);

    // T3: a full row wraps; a control byte is swallowed
    do_clear();
    for (int i = 0; i < 40; i++) send(8'hB0, we);
    wait_ready("t3", 20);
    chk("t3_nwrites", wq_addr.size(), 40);
    chk_seg("t3_seq", 0, 0, 40, 48);
    chk("t3_col", int'(cursor_col), 0);
    chk("t3_row", int'(cursor_row), 1);
    qclear();
    send(8'h07, we);
    repeat (3) @(negedge clk);
    chk("t3_bel_we", we, 0);
    chk("t3_bel_nwrites", wq_addr.size(), 0);
    chk("t3_bel_col", int'(cursor_col), 0);
    chk("t3_bel_row", int'(cursor_row), 1);

    // T4: CR on the last row scrolls and blanks the recycled physical row 0
    for (int i = 0; i < 22; i++) send(8'h8D, we);
    wait_ready("t4a", 20);
    chk("t4_row23", int'(cursor_row), 23);
    qclear();
    send(8'h8D, we);
    wait_ready("t4b", 100);
    chk("t4_nwrites", wq_addr.size(), 40);
    chk_seg("t4_line", 0, 0, 40, 32);
    chk("t4_offset", int'(row_offset), 1);
    chk("t4_col", int'(cursor_col), 0);
    chk("t4_row", int'(cursor_row), 23);
    qclear();
    send(8'hC2, we);
    wait_ready("t4c", 20);
    chk("t4_b_nwrites", wq_addr.size(), 1);
    chk_seg("t4_b", 0, 0, 1, 2);

    // T5a: clr and a byte together: clear wins, byte dropped
    qclear();
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_char = 8'hC3;
    #1;
    chk("t5_blocked", int'(in_ready), 0);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    wait_ready("t5a", 2000);
    chk("t5a_nwrites", wq_addr.size(), 960);
    chk_seg("t5a_seq", 0, 0, 960, 32);
    chk("t5a_offset", int'(row_offset), 0);
    chk("t5a_col", int'(cursor_col), 0);

    // T5b: clr during CLEAR_LINE -> line finishes, then a full clear
    for (int i = 0; i < 23; i++) send(8'h8D, we);
    qclear();
    send(8'h8D, we);
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    wait_ready("t5b", 3000);
    chk("t5b_nwrites", wq_addr.size(), 1000);
    chk_seg("t5b_line", 0, 0, 40, 32);
    chk_seg("t5b_full", 40, 0, 960, 32);
    chk("t5b_offset", int'(row_offset), 0);
    chk("t5b_row", int'(cursor_row), 0);

    // T6: rst on the 20th CLEAR_LINE cycle aborts and restarts the full clear
    for (int i = 0; i < 23; i++) send(8'h8D, we);
    qclear();
    send(8'h8D, we);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_partial", wq_addr.size(), 19);
    chk("t6_we", int'(vram_we), 0);
    chk("t6_addr", int'(vram_addr), 0);
    chk("t6_wdata", int'(vram_wdata), 32);
    chk("t6_offset", int'(row_offset), 0);
    chk("t6_row", int'(cursor_row), 0);
    chk("t6_busy", int'(busy), 1);
    chk("t6_ready", int'(in_ready), 0);
    rst = 1'b0;
    qclear();
    wait_ready("t6", 2000);
    chk("t6_nwrites", wq_addr.size(), 960);
    chk_seg("t6_seq", 0, 0, 960, 32);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
